// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues sequential word fetches to a
// 1-cycle synchronous instruction memory and buffers returned words in a prefetch FIFO.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        dec_ready,
   output logic        ins_valid,
   output logic [31:0] ins_out,
   output logic [31:0] ins_pc
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] CNT_ONE = 1;
   localparam logic [PW-1:0] PTR_ONE = 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);

   logic [31:0]   pc;
   logic [31:0]   resp_pc;
   logic          inflight;
   logic [CW-1:0] count;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   buf_ins [FIFO_DEPTH];
   logic [31:0]   buf_pc  [FIFO_DEPTH];

   logic [CW:0]   occ;
   logic          push;
   logic          pop;

   // Counting the in-flight word against capacity guarantees a slot for every response.
   assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign imem_req  = rst & ~redirect_valid & (occ < DEPTH_W);
   assign imem_addr = pc;

   assign push      = rst & ~redirect_valid & inflight;
   assign ins_valid = rst & ~redirect_valid & (count != '0);
   assign pop       = ins_valid & dec_ready;
   assign ins_out   = buf_ins[rd_ptr];
   assign ins_pc    = buf_pc[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc       <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc & 32'hFFFF_FFFC;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         assert (!(push && count == DEPTH_C));
         inflight <= imem_req;
         if (imem_req) begin
            pc      <= pc + 32'd4;
            resp_pc <= pc;
         end
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_ins[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]  <= resp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized-redirect checks for fetch_unit, with a second instance
// started near the top of the address space to cover PC wrap.
module tb_fetch_unit;

   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic        imem_req;
   logic        ins_valid;
   logic [31:0] ins_out, ins_pc;

   logic        w_redir_valid;
   logic [31:0] w_redir_pc;
   logic [31:0] w_addr, w_rdata;
   logic        w_req;
   logic        w_vld;
   logic [31:0] w_ins, w_pc;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .dec_ready(dec_ready), .ins_valid(ins_valid),
      .ins_out(ins_out), .ins_pc(ins_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
      .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_req(w_req),
      .imem_rdata(w_rdata), .redirect_valid(w_redir_valid),
      .redirect_pc(w_redir_pc), .dec_ready(dec_ready), .ins_valid(w_vld),
      .ins_out(w_ins), .ins_pc(w_pc)
   );

   always @(posedge clk) begin
      if (imem_req) imem_rdata <= imem_addr ^ K;
      if (w_req)    w_rdata    <= w_addr ^ K;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
   endtask

   logic [31:0] wrap_exp [4];
   logic [31:0] e;
   logic [31:0] tgt;
   logic [31:0] exp_pc;
   int          next_redir;
   int          occ;
   int          max_occ;
   int          ndeliv;

   initial begin
      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;
      wrap_exp[3] = 32'h0000_0004;
      w_redir_valid  = 1'b0;
      w_redir_pc     = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      dec_ready      = 1'b1;
      rst            = 1'b0;
      #1;
      chk("rst_req_early", 32'(imem_req), 32'd0);
      chk("rst_vld_early", 32'(ins_valid), 32'd0);
      tick();
      tick();
      #1;
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr_w", w_addr, 32'hFFFF_FFF8);

      // streaming from reset, plus wrap on the second instance
      rst = 1'b1;
      #1;
      chk("s_req0", 32'(imem_req), 32'd1);
      chk("s_addr0", imem_addr, 32'h0);
      tick();
      chk("s_vld_c1", 32'(ins_valid), 32'd0);
      chk("s_addr1", imem_addr, 32'h4);
      for (int k = 0; k < 6; k++) begin
         tick();
         e = 32'(4 * k);
         chk("s_vld", 32'(ins_valid), 32'd1);
         chk("s_pc", ins_pc, e);
         chk("s_ins", ins_out, e ^ K);
         if (k < 4) begin
            chk("wrap_vld", 32'(w_vld), 32'd1);
            chk("wrap_pc", w_pc, wrap_exp[k]);
         end
      end

      // back-pressure fills the FIFO, then drains in order
      dec_ready = 1'b0;
      do_reset();
      rst = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      chk("st_req", 32'(imem_req), 32'd0);
      chk("st_addr", imem_addr, 32'd16);
      chk("st_vld", 32'(ins_valid), 32'd1);
      chk("st_head", ins_pc, 32'd0);
      dec_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) tick();
         e = 32'(4 * k);
         chk("dr_vld", 32'(ins_valid), 32'd1);
         chk("dr_pc", ins_pc, e);
         chk("dr_ins", ins_out, e ^ K);
      end

      // redirect with two buffered entries and one in flight
      dec_ready = 1'b0;
      do_reset();
      rst = 1'b1;
      tick();
      tick();
      tick();
      chk("rd_pre_pc", ins_pc, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      #1;
      chk("rd_vld_cyc", 32'(ins_valid), 32'd0);
      chk("rd_req_cyc", 32'(imem_req), 32'd0);
      tick();
      redirect_valid = 1'b0;
      dec_ready      = 1'b1;
      #1;
      chk("rd_addr", imem_addr, 32'h0000_0100);
      chk("rd_req", 32'(imem_req), 32'd1);
      chk("rd_vld1", 32'(ins_valid), 32'd0);
      tick();
      chk("rd_vld2", 32'(ins_valid), 32'd0);
      tick();
      chk("rd_vld3", 32'(ins_valid), 32'd1);
      chk("rd_pc3", ins_pc, 32'h0000_0100);
      chk("rd_ins3", ins_out, 32'h0000_0100 ^ K);
      tick();
      chk("rd_pc4", ins_pc, 32'h0000_0104);

      // reset and redirect together mid-stream with three buffered
      dec_ready = 1'b0;
      do_reset();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      chk("rr_pre_vld", 32'(ins_valid), 32'd1);
      rst            = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      dec_ready      = 1'b1;
      #1;
      chk("rr_vld0", 32'(ins_valid), 32'd0);
      chk("rr_req0", 32'(imem_req), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("rr_vld1", 32'(ins_valid), 32'd0);
      chk("rr_req1", 32'(imem_req), 32'd0);
      chk("rr_addr", imem_addr, 32'h0);
      tick();
      rst = 1'b1;
      #1;
      chk("rr_req_rel", 32'(imem_req), 32'd1);
      chk("rr_addr_rel", imem_addr, 32'h0);
      tick();
      chk("rr_vld_c1", 32'(ins_valid), 32'd0);
      tick();
      chk("rr_vld_c2", 32'(ins_valid), 32'd1);
      chk("rr_pc_c2", ins_pc, 32'h0);
      chk("rr_ins_c2", ins_out, K);

      // random back-pressure with periodic redirects
      next_redir = 0;
      occ        = 0;
      max_occ    = 0;
      ndeliv     = 0;
      exp_pc     = 32'h0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (i == next_redir) begin
            tgt            = $urandom;
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
            next_redir     = i + int'($urandom_range(50, 20));
         end else begin
            redirect_valid = 1'b0;
         end
         dec_ready = 1'($urandom_range(1, 0));
         #1;
         if (redirect_valid) begin
            chk("r_vld_redir", 32'(ins_valid), 32'd0);
            exp_pc = tgt & 32'hFFFF_FFFC;
            occ    = 0;
         end else begin
            if (ins_valid && dec_ready) begin
               chk("r_pc", ins_pc, exp_pc);
               chk("r_ins", ins_out, exp_pc ^ K);
               exp_pc = exp_pc + 32'd4;
               ndeliv++;
               occ--;
            end
            if (imem_req) occ++;
            if (occ > max_occ) max_occ = occ;
         end
      end
      redirect_valid = 1'b0;
      chk("r_occ_max_le4", 32'(max_occ <= 4), 32'd1);
      chk("r_deliv_some", 32'(ndeliv > 100), 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that produces the instruction stream consumed by the register-read/decode stage.
- Owns the program counter and issues sequential word fetches to a synchronous-read instruction memory (1-cycle read latency).
- Buffers returned instructions with their PCs in a small prefetch FIFO, so decode back-pressure never drops a fetch.
- Accepts a redirect (branch/jump target) from the execute stage, which flushes all buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 4, prefetch FIFO entries; a power of two, minimum 2.

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
imem_addr  out  32  fetch address, equal to the current PC register
imem_req  out  1  fetch request this cycle; data is returned on imem_rdata in the next cycle
imem_rdata  in  32  instruction word, valid the cycle after imem_req=1
redirect_valid  in  1  pulse: discard the stream and restart at redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0
dec_ready  in  1  decode stage accepts the head instruction this cycle
ins_valid  out  1  head instruction is valid
ins_out  out  32  head instruction word
ins_pc  out  32  PC of the head instruction

Behaviour:
- Reset (rst=0 at an edge):
  - pc <= RESET_PC; FIFO count <= 0; inflight <= 0.
  - imem_req=0 and ins_valid=0 while rst=0; ins_out and ins_pc hold don't-care values.
  - Reset overrides redirect_valid and dec_ready, and discards any in-flight response.
- Fetch request (combinational):
  - imem_req = rst & ~redirect_valid & ((count + inflight) < FIFO_DEPTH).
  - imem_addr = pc at all times.
  - No pop credit is taken; this still sustains 1 instruction/cycle when dec_ready is held at 1.
- On each edge with imem_req=1: pc <= pc + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0); inflight <= 1; the issued PC is latched as resp_pc.
- On each edge with imem_req=0: inflight <= 0.
- Response: when inflight=1 and there is no redirect this cycle, push {imem_rdata, resp_pc} into the FIFO at the edge.
- Output and pop:
  - ins_valid = (count != 0) & ~redirect_valid.
  - ins_out and ins_pc show the FIFO head.
  - Pop when ins_valid & dec_ready.
  - A push and a pop in the same cycle leave count unchanged. Ordering is strict FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
- Full/empty:
  - The request gating guarantees a push never occurs while count = FIFO_DEPTH; an overflow is a design error and should be asserted.
  - A pop is never performed while empty.
- Redirect (redirect_valid=1 at an edge, rst=1):
  - count <= 0 and pointers reset.
  - The in-flight response is discarded (not pushed).
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No request is issued and no pop occurs in that cycle.
  - The first request to the target is issued in the next cycle.
- Latency:
  - The first request is issued in the first cycle with rst=1.
  - Redirect to first ins_valid is 3 edges: redirect edge, request edge, push edge.
  - Request to ins_valid on an empty FIFO is 2 edges.
- Back-to-back redirects: each one restarts the stream; only the last target survives.

Test Plan:
- Reset release with dec_ready=1 and imem returning mem[addr>>2]=addr ^ 32'hA5A5_0000: ins_valid rises 2 cycles after the first request; ins_pc sequence is 0, 4, 8, 12, … at 1/cycle; ins_out matches.
- dec_ready=0 for 10 cycles: exactly FIFO_DEPTH=4 entries are buffered; imem_req drops to 0; pc=16. Then dec_ready=1: PCs 0, 4, 8, 12, 16 are delivered in order with no gap or duplicate.
- Redirect to 32'h0000_0103 while inflight=1 and count=2: ins_valid=0 in the redirect cycle; the buffered and in-flight words never appear; the next ins_pc is 32'h0000_0100, 3 cycles later.
- RESET_PC=32'hFFFF_FFF8, streaming: ins_pc sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst=0 mid-stream with count=3 and a redirect pulse in the same cycle: the next cycle has ins_valid=0 and imem_req=0; after release, fetch restarts at RESET_PC and no stale instruction appears.
- Random dec_ready (50%) for 1000 cycles with random redirects every 20–50 cycles: the scoreboard sees each delivered ins_pc = previous+4 or the latest redirect target, and never more than 4 buffered entries.
